regfile: RTL
============

// Module: regfile
// PURPOSE
//  - General-purpose register file answering the decode stage's two read requests (enable+addr -> data) and taking one write from write-back.
//  - Storage is a 2R1W array with no reset on the cells; after reset a sequencer zeroes r1..r31, one per cycle, and holds the pipeline off via init_busy.
//  - r0 is hardwired to zero. A write-back write is visible to decode in the same cycle through the write-to-read bypass.
// PARAMETERS
//  REG_NUM   32  number of architectural registers (r0 included)
//  ADDR_W    5   register address width, log2(REG_NUM)
//  DATA_W    32  register data width
// PORTS
//  clk        in   1       clock; all state updates on rising edge
//  rst        in   1       reset, synchronous, active-high
//  we         in   1       write enable from write-back (`WriteEnable)
//  waddr      in   ADDR_W  write register number
//  wdata      in   DATA_W  write data
//  re1        in   1       read port 1 enable (`ReadEnable)
//  raddr1     in   ADDR_W  read port 1 register number
//  rdata1     out  DATA_W  read port 1 data, combinational
//  re2        in   1       read port 2 enable
//  raddr2     in   ADDR_W  read port 2 register number
//  rdata2     out  DATA_W  read port 2 data, combinational
//  init_busy  out  1       registered; 1 while clearing, to be ORed into the pipeline stall request
// BEHAVIOUR
//  - State: CLEAR / READY, plus a clear counter clr_cnt[ADDR_W-1:0].
//  - Reset: rst=1 at edge k gives state=CLEAR, clr_cnt=1, init_busy=1. The array is not touched at edge k.
//  - Reset output values:
//    - rdata1 and rdata2 are forced to `ZeroWord combinationally while rst=1.
//    - init_busy is 1 from edge k onward.
//  - CLEAR:
//    - Each edge writes 0 to regs[clr_cnt] and increments clr_cnt.
//    - The edge that clears r(REG_NUM-1) also sets state=READY and init_busy=0.
//    - With rst low from edge k+1, busy covers exactly REG_NUM-1 = 31 edges (k+1..k+31); READY holds after edge k+31.
//  - In CLEAR, the write port is ignored (write dropped) and both reads return `ZeroWord.
//  - READY write: at an edge with we=1 and waddr!=0, regs[waddr] <= wdata. A write to r0 is discarded.
//  - READY read, per port n, evaluated in priority order:
//    1. re_n=0 -> 0.
//    2. raddr_n=0 -> 0.
//    3. we=1 && waddr==raddr_n -> wdata (bypass).
//    4. Otherwise regs[raddr_n].
//  - Both ports are independent. The same address on both ports gives identical data, bypass included.
//  - Reset during CLEAR restarts the sequence at r1. Reset during READY drops any write presented at that edge and re-enters CLEAR.
//  - Read latency is 0 cycles (combinational). A write takes effect at the next edge and is bypassed before it.
//  - The clear counter wraps only via the state change. clr_cnt is never 0 in CLEAR.
// STRUCTURE
//  - defines.v gains:
//    - `RegNum (32), `RegNumLog2 (5).
//    - `RfClear / `RfReady state encodings.
//    - Reuses `RegBus, `RegAddrBus, `ZeroWord, `ReadEnable, `WriteEnable.
//  - Sub-module regfile_ram: a plain 2R1W array with async read, sync write, and no reset. It is inferable as distributed RAM.
//  - regfile owns the state machine, the clear counter, the write mux (clear vs write-back), and the read bypass/zero logic.
// TESTING
//  1. Reset for 1 cycle, release:
//     - init_busy=1 for exactly 31 edges, then 0.
//     - Every read of r1..r31 returns 0x00000000 afterwards.
//  2. READY: write r5=0xDEADBEEF with re1=1, raddr1=5 in the same cycle:
//     - rdata1=0xDEADBEEF combinationally (bypass).
//     - Next cycle, with we=0, rdata1 still reads 0xDEADBEEF.
//  3. Write r0=0xFFFFFFFF, then read raddr1=raddr2=0:
//     - Both ports return 0, including in the write cycle (no bypass for r0).
//  4. re2=0 with raddr2=5 holding 0x12345678 -> rdata2=0.
//     Both ports reading r7=0xA5A5A5A5 -> both return 0xA5A5A5A5.
//  5. During CLEAR (clr_cnt=10), assert we with waddr=3, wdata=0x11:
//     - The write is dropped; r3 reads 0 after READY.
//     - Pulse rst mid-CLEAR: busy restarts, 31 more edges.
//  6. READY with r9=0x55: assert rst together with we (waddr=9, wdata=0x77):
//     - The write is dropped and r9 reads 0 after the clear.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the general-purpose register file.
//
// Contents:
//   REG_NUM / ADDR_W / DATA_W  architectural register count, address and data widths
//   ZERO_WORD, READ_ENABLE, WRITE_ENABLE   common constants used by the datapath
//   LAST_REG                   highest register number, the final register cleared after reset
//   rf_state_e                 CLEAR / READY sequencer states
//   rf_read_mux()              per-port read selection (zero, bypass or array data)
package regfile_pkg;

    localparam int REG_NUM = 32;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;

    localparam logic [DATA_W-1:0] ZERO_WORD    = '0;
    localparam logic              READ_ENABLE  = 1'b1;
    localparam logic              WRITE_ENABLE = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(REG_NUM - 1);

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    // Read data for one port. Priority: not ready, port disabled, r0,
    // same-cycle write-back bypass, then the stored value.
    function automatic logic [DATA_W-1:0] rf_read_mux(
        input logic              ready,
        input logic              re,
        input logic [ADDR_W-1:0] raddr,
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] ram_data
    );
        logic [DATA_W-1:0] result;
        if (!ready) begin
            result = ZERO_WORD;
        end else if (re != READ_ENABLE) begin
            result = ZERO_WORD;
        end else if (raddr == '0) begin
            result = ZERO_WORD;
        end else if ((we == WRITE_ENABLE) && (waddr == raddr)) begin
            result = wdata;
        end else begin
            result = ram_data;
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_ram.sv
// Plain 2-read / 1-write storage array for the register file.
// Asynchronous reads, synchronous write, no reset on the cells, so the
// array maps onto distributed RAM.
//
// Ports:
//   clk_i                 clock, write on rising edge
//   we_i, waddr_i, wdata_i   write port
//   raddr1_i -> rdata1_o  read port 1 (combinational)
//   raddr2_i -> rdata2_o  read port 2 (combinational)
module regfile_ram
    import regfile_pkg::*;
(
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o
);

    logic [DATA_W-1:0] mem_q [REG_NUM];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = mem_q[raddr1_i];
    assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/regfile.sv
// General-purpose register file: two combinational read ports for decode,
// one write port from write-back. The storage cells have no reset; after
// reset a sequencer zeroes r1..r31 one per cycle while init_busy stalls the
// pipeline. r0 always reads zero, and a write-back write is bypassed to the
// read ports in the same cycle.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   we, waddr, wdata           write-back write port
//   re1, raddr1 -> rdata1      read port 1 (combinational)
//   re2, raddr2 -> rdata2      read port 2 (combinational)
//   init_busy                  registered, high while the array is being cleared
module regfile
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              init_busy
);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              busy_q, busy_d;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata1;
    logic [DATA_W-1:0] ram_rdata2;
    logic              rd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RF_CLEAR;
            clr_cnt_q <= ADDR_W'(1);
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
        end
    end

    // Next state plus the write mux: the clear sequencer owns the array
    // write port in CLEAR, write-back owns it in READY.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy_d    = busy_q;
        ram_we    = 1'b0;
        ram_waddr = waddr;
        ram_wdata = wdata;

        case (state_q)
            RF_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt_q;
                ram_wdata = ZERO_WORD;
                // Wraps to 0 only on the same edge that leaves CLEAR.
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                busy_d    = 1'b1;
                if (clr_cnt_q == LAST_REG) begin
                    state_d = RF_READY;
                    busy_d  = 1'b0;
                end
            end
            RF_READY: begin
                busy_d = 1'b0;
                ram_we = (we == WRITE_ENABLE) && (waddr != '0);
            end
            default: begin
                state_d = RF_CLEAR;
            end
        endcase

        // A reset edge never touches the array, including a write presented with it.
        if (rst) begin
            ram_we = 1'b0;
        end
    end

    regfile_ram u_ram (
        .clk_i    (clk),
        .we_i     (ram_we),
        .waddr_i  (ram_waddr),
        .wdata_i  (ram_wdata),
        .raddr1_i (raddr1),
        .rdata1_o (ram_rdata1),
        .raddr2_i (raddr2),
        .rdata2_o (ram_rdata2)
    );

    // Reads are forced to zero while reset is asserted and throughout CLEAR.
    assign rd_ready = (state_q == RF_READY) && !rst;

    assign rdata1 = rf_read_mux(rd_ready, re1, raddr1, we, waddr, wdata, ram_rdata1);
    assign rdata2 = rf_read_mux(rd_ready, re2, raddr2, we, waddr, wdata, ram_rdata2);

    assign init_busy = busy_q;

endmodule
